keypad_scanner: RTL and testbench

//   Scans a 4x4 matrix keypad and debounces each press. Each accepted press is

---
 rtl/keypad_scanner.sv | 160 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column rotation, 2-flop row sync, full-scan
// debounce and a first-word-fall-through key-code queue.
module keypad_scanner #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       internal_reset_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);
  localparam int TICK   = CLK_HZ / SCAN_HZ;
  localparam int TICK_W = $clog2(TICK);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [0:0] DEB_NONE = 1'b0;
  localparam logic [0:0] DEB_KEY  = 1'b1;

  logic [3:0]        row_s1_q, row_s2_q;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [15:0]       samp_q, samp_d;
  logic [0:0]        deb_state_q, deb_state_d;
  logic [3:0]        deb_code_q, deb_code_d;
  logic              prev_key_q, prev_key_d;
  logic [3:0]        prev_code_q, prev_code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FIFO_DEPTH-1:0][3:0] mem_q, mem_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    occ_q, occ_d;
  logic              overflow_q, overflow_d;

  logic       sample_en, scan_done, cand_key, same_deb, same_prev, push, pop, full;
  logic [3:0] cand_code, idx;
  logic [4:0] n_pressed;

  always_comb begin
    sample_en = (tick_q == TICK_W'(TICK - 1));
    scan_done = sample_en && (col_idx_q == 2'd3);
    tick_d    = sample_en ? '0 : tick_q + 1'b1;
    col_idx_d = sample_en ? col_idx_q + 2'd1 : col_idx_q;
    col_n     = ~(4'b0001 << col_idx_q);

    // samp bit {row,col} is 1 when that key was seen closed this scan
    samp_d = samp_q;
    idx    = '0;
    if (sample_en) begin
      for (int r = 0; r < 4; r++) begin
        idx         = {2'(r), col_idx_q};
        samp_d[idx] = ~row_s2_q[r];
      end
    end

    n_pressed = '0;
    cand_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (samp_d[i]) begin
        n_pressed = n_pressed + 5'd1;
        cand_code = 4'(i);
      end
    end
    // ghosted multi-key scans are treated as no key
    cand_key = (n_pressed == 5'd1);

    same_deb  = (cand_key == (deb_state_q == DEB_KEY)) && (!cand_key || cand_code == deb_code_q);
    same_prev = (cand_key == prev_key_q) && (!cand_key || cand_code == prev_code_q);

    deb_state_d = deb_state_q;
    deb_code_d  = deb_code_q;
    prev_key_d  = prev_key_q;
    prev_code_d = prev_code_q;
    cnt_d       = cnt_q;
    push        = 1'b0;
    if (scan_done) begin
      prev_key_d  = cand_key;
      prev_code_d = cand_code;
      if (same_deb)       cnt_d = '0;
      else if (same_prev) cnt_d = cnt_q + 1'b1;
      else                cnt_d = CNT_W'(1);
      if (cnt_d >= CNT_W'(DEBOUNCE_SCANS)) begin
        deb_state_d = cand_key ? DEB_KEY : DEB_NONE;
        deb_code_d  = cand_code;
        cnt_d       = '0;
        push        = cand_key;
      end
    end
  end

  always_comb begin
    key_valid  = (occ_q != '0);
    key_code   = key_valid ? mem_q[rd_ptr_q] : 4'h0;
    key_held   = (deb_state_q == DEB_KEY);
    overflow   = overflow_q;
    pop        = key_valid && key_ready;
    full       = (occ_q == (PTR_W + 1)'(FIFO_DEPTH));
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    overflow_d = 1'b0;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      occ_d    = occ_q - 1'b1;
    end
    // a pop on the same edge frees the slot the push needs
    if (push) begin
      if (!full || pop) begin
        mem_d[wr_ptr_q] = cand_code;
        wr_ptr_d        = wr_ptr_q + 1'b1;
        occ_d           = occ_d + 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge internal_reset_n) begin
    if (!internal_reset_n) begin
      row_s1_q    <= 4'b1111;
      row_s2_q    <= 4'b1111;
      tick_q      <= '0;
      col_idx_q   <= '0;
      samp_q      <= '0;
      deb_state_q <= DEB_NONE;
      deb_code_q  <= '0;
      prev_key_q  <= 1'b0;
      prev_code_q <= '0;
      cnt_q       <= '0;
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      row_s1_q    <= row_n;
      row_s2_q    <= row_s1_q;
      tick_q      <= tick_d;
      col_idx_q   <= col_idx_d;
      samp_q      <= samp_d;
      deb_state_q <= deb_state_d;
      deb_code_q  <= deb_code_d;
      prev_key_q  <= prev_key_d;
      prev_code_q <= prev_code_d;
      cnt_q       <= cnt_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      overflow_q  <= overflow_d;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner: a keypad model drives rows from the
// column drive, and a scan-level reference predicts every output each cycle.
module tb_keypad_scanner;
  localparam int DEB   = 2;
  localparam int DEPTH = 4;
  localparam int SCAN  = 16;

  logic       clock = 1'b0;
  logic       internal_reset_n = 1'b0;
  logic [3:0] row_n, col_n, key_code;
  logic       key_valid, key_ready = 1'b0, key_held, overflow;
  logic [3:0][3:0] mask = '0;

  keypad_scanner #(.CLK_HZ(16), .SCAN_HZ(4), .DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .internal_reset_n(internal_reset_n), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_held(key_held), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // pressed key (r,c) pulls row r low while column c is driven low
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r][c] && !col_n[c]) row_n[r] = 1'b0;
  end

  int n_vec = 0, n_err = 0;
  int cyc, deb, prev, cnt;
  bit ovf_m;
  int q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int scan_cand(input logic [15:0] m);
    if ($countones(m) != 1) return -1;
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic check_outputs();
    chk("col_n", {28'd0, col_n}, {28'd0, ~(4'b0001 << ((cyc / 4) % 4))});
    chk("key_valid", {31'd0, key_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) chk("key_code", {28'd0, key_code}, q[0]);
    chk("key_held", {31'd0, key_held}, {31'd0, deb >= 0});
    chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
  endtask

  task automatic cycle(input bit rdy);
    int e, cand;
    key_ready = rdy;
    e = cyc + 1;
    ovf_m = 0;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (e % SCAN == 0) begin
      cand = scan_cand(mask);
      if (cand == deb)       cnt = 0;
      else if (cand == prev) cnt++;
      else                   cnt = 1;
      prev = cand;
      if (cnt >= DEB) begin
        deb = cand;
        cnt = 0;
        if (cand >= 0) begin
          if (q.size() < DEPTH) q.push_back(cand);
          else ovf_m = 1;
        end
      end
    end
    @(posedge clock);
    cyc = e;
    @(negedge clock);
    check_outputs();
  endtask

  task automatic run_scans(input logic [15:0] m, input int n, input int rdy_pct);
    mask = m;
    for (int i = 0; i < n * SCAN; i++) cycle($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic do_reset();
    #2;
    internal_reset_n = 1'b0;
    #1;
    chk("rst_col_n", {28'd0, col_n}, 32'hE);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_held", {31'd0, key_held}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_code", {28'd0, key_code}, 32'd0);
    mask = '0;
    key_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    internal_reset_n = 1'b1;
    cyc = 0; deb = -1; prev = -1; cnt = 0; ovf_m = 0;
    q.delete();
    check_outputs();
  endtask

  initial begin
    int kind, a, b;
    logic [15:0] m;
    @(negedge clock);
    do_reset();
    // idle rotation
    run_scans(16'h0, 2, 100);
    // single held key, no auto-repeat
    run_scans(16'h0040, 10, 100);
    run_scans(16'h0, 3, 100);
    // one-scan bounce
    run_scans(16'h1000, 1, 100);
    run_scans(16'h0, 3, 100);
    // ghosting pair, then the survivor alone
    run_scans(16'h0802, 3, 100);
    run_scans(16'h0002, 2, 100);
    run_scans(16'h0, 3, 100);
    // fill past depth with consumer stalled, then drain
    for (int k = 1; k <= 5; k++) run_scans(16'(1 << k), 2, 0);
    run_scans(16'h0, 3, 100);
    // reset with two queued codes and a debounce in flight
    run_scans(16'h0002, 2, 0);
    run_scans(16'h0004, 2, 0);
    run_scans(16'h0008, 1, 0);
    chk("pre_rst_occ", {31'd0, key_valid}, 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0);
    do_reset();
    run_scans(16'h0, 1, 100);
    // random presses, ghosts and consumer stalls
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 4);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      m = '0;
      if (kind >= 1) m[a] = 1'b1;
      if (kind == 4) m[b] = 1'b1;
      run_scans(m, $urandom_range(1, 3), $urandom_range(0, 100));
    end
    run_scans(16'h0, 4, 100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
